// File: rtl/dma_pkg.sv
// Shared types and constants for the peripheral DMA responder.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DEV,
        ST_MEM_REQ,
        ST_RD_CAP,
        ST_ACK,
        ST_END,
        ST_ERROR,
        ST_DRAIN
    } dma_state_e;

    localparam logic        DIR_WRITE       = 1'b0;
    localparam logic        DIR_READ        = 1'b1;
    localparam logic [15:0] ACK_TIMEOUT_DEF = 16'd1024;

    // Reads never touch memory bytes; writes always store the full word.
    function automatic logic [1:0] we_for_dir(input logic dir);
        return (dir == DIR_READ) ? 2'b00 : 2'b11;
    endfunction

endpackage

// File: rtl/dma_if.sv
// Device-side and memory-side buses of the DMA responder.
interface dma_dev_if;
    logic        dev_rqst;
    logic        dev_rd_wr;
    logic [15:0] dev_start_addr;
    logic [15:0] dev_num_words;
    logic        dev_ack;
    logic [15:0] dev_wdata;
    logic [15:0] dev_rdata;
    logic        dev_dma_ack;
    logic        dev_end_flag;
    logic        dev_error_flag;

    // master = requesting peripheral, slave = DMA controller
    modport master (
        output dev_rqst, dev_rd_wr, dev_start_addr, dev_num_words, dev_ack, dev_wdata,
        input  dev_rdata, dev_dma_ack, dev_end_flag, dev_error_flag
    );
    modport slave (
        input  dev_rqst, dev_rd_wr, dev_start_addr, dev_num_words, dev_ack, dev_wdata,
        output dev_rdata, dev_dma_ack, dev_end_flag, dev_error_flag
    );
endinterface

interface dma_mem_if;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_priority;
    logic [15:0] dma_dout;
    logic        dma_ready;
    logic        dma_resp;

    // master = DMA controller, slave = memory backbone port
    modport master (
        output dma_addr, dma_din, dma_en, dma_we, dma_priority,
        input  dma_dout, dma_ready, dma_resp
    );
    modport slave (
        input  dma_addr, dma_din, dma_en, dma_we, dma_priority,
        output dma_dout, dma_ready, dma_resp
    );
endinterface

// File: rtl/dma_xfer_counter.sv
// Word-address and remaining-count tracking for one DMA block.
module dma_xfer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [14:0] load_addr,
    input  logic [15:0] load_cnt,
    input  logic        step,
    output logic [14:0] word_addr,
    output logic        zero_on_step
);

    logic [15:0] remaining;

    // Address wraps naturally mod 2^15; a step past 0x7FFF is legal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_addr <= '0;
            remaining <= '0;
        end else if (load) begin
            word_addr <= load_addr;
            remaining <= load_cnt;
        end else if (step) begin
            word_addr <= word_addr + 15'd1;
            remaining <= remaining - 16'd1;
        end
    end

    // Count becomes zero with the step taken this cycle.
    assign zero_on_step = (remaining == 16'd1);

endmodule

// File: rtl/dma_controller.sv
// Responder end of the peripheral DMA protocol: one memory access per device handshake.
module dma_controller
    import dma_pkg::*;
#(
    parameter logic [15:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter logic        PRIORITY    = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    dma_dev_if.slave  dev,
    dma_mem_if.master mem
);

    dma_state_e  state, state_nx;
    logic        rd_wr_q;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        load, step, zero_on_step, enter_mem;
    logic [14:0] word_addr;

    logic        en_q, en_nx;
    logic [1:0]  we_q, we_nx;
    logic [14:0] addr_q, addr_nx;
    logic [15:0] din_q, din_nx;
    logic [15:0] rdata_q, rdata_nx;
    logic        dack_q, dack_nx;
    logic        end_q, end_nx;
    logic        err_q, err_nx;

    // Byte address LSB carries no information for word transfers.
    logic unused_addr_lsb;
    assign unused_addr_lsb = dev.dev_start_addr[0];

    assign load = (state == ST_IDLE) && dev.dev_rqst;
    assign step = (state == ST_ACK);

    dma_xfer_counter u_cnt (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_addr   (dev.dev_start_addr[15:1]),
        .load_cnt    (dev.dev_num_words),
        .step        (step),
        .word_addr   (word_addr),
        .zero_on_step(zero_on_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_wr_q <= DIR_WRITE;
            tmo_cnt <= '0;
        end else begin
            if (load) rd_wr_q <= dev.dev_rd_wr;
            tmo_cnt <= (state == ST_WAIT_DEV) ? tmo_cnt + 16'd1 : 16'd0;
        end
    end

    // tmo_cnt holds cycles already spent in WAIT_DEV; this one completes the budget.
    assign tmo_hit = (ACK_TIMEOUT != 16'd0) &&
                     (({1'b0, tmo_cnt} + 17'd1) == {1'b0, ACK_TIMEOUT});

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:
                if (dev.dev_rqst)
                    state_nx = (dev.dev_num_words == 16'd0) ? ST_END : ST_WAIT_DEV;
            ST_WAIT_DEV:
                if (!dev.dev_rqst)    state_nx = ST_IDLE;
                else if (dev.dev_ack) state_nx = ST_MEM_REQ;
                else if (tmo_hit)     state_nx = ST_ERROR;
            ST_MEM_REQ:
                if (mem.dma_ready) begin
                    if (mem.dma_resp)             state_nx = ST_ERROR;
                    else if (rd_wr_q == DIR_READ) state_nx = ST_RD_CAP;
                    else                          state_nx = ST_ACK;
                end
            ST_RD_CAP: state_nx = ST_ACK;
            ST_ACK:    state_nx = zero_on_step ? ST_END : ST_WAIT_DEV;
            ST_END:    state_nx = ST_DRAIN;
            ST_ERROR:  state_nx = ST_DRAIN;
            ST_DRAIN:  if (!dev.dev_rqst) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    assign enter_mem = (state == ST_WAIT_DEV) && (state_nx == ST_MEM_REQ);

    always_comb begin
        en_nx    = (state_nx == ST_MEM_REQ);
        we_nx    = en_nx ? we_for_dir(rd_wr_q) : 2'b00;
        addr_nx  = enter_mem ? word_addr     : addr_q;
        din_nx   = enter_mem ? dev.dev_wdata : din_q;
        rdata_nx = (state == ST_RD_CAP) ? mem.dma_dout : rdata_q;
        dack_nx  = (state_nx == ST_ACK);
        end_nx   = (state_nx == ST_END);
        err_nx   = (state_nx == ST_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            we_q    <= 2'b00;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            dack_q  <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            en_q    <= en_nx;
            we_q    <= we_nx;
            addr_q  <= addr_nx;
            din_q   <= din_nx;
            rdata_q <= rdata_nx;
            dack_q  <= dack_nx;
            end_q   <= end_nx;
            err_q   <= err_nx;
        end
    end

    assign mem.dma_en         = en_q;
    assign mem.dma_we         = we_q;
    assign mem.dma_addr       = addr_q;
    assign mem.dma_din        = din_q;
    assign mem.dma_priority   = PRIORITY;
    assign dev.dev_rdata      = rdata_q;
    assign dev.dev_dma_ack    = dack_q;
    assign dev.dev_end_flag   = end_q;
    assign dev.dev_error_flag = err_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed cycle-by-cycle vectors plus hand sequences for timeout, wrap and reset.
module tb_dma_controller;
    import dma_pkg::*;

    typedef struct packed {
        logic        rqst;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] num;
        logic        ack;
        logic [15:0] wdata;
        logic        ready;
        logic        resp;
        logic [15:0] dout;
    } vin_t;

    typedef struct packed {
        logic        en;
        logic [1:0]  we;
        logic [14:0] maddr;
        logic [15:0] din;
        logic        dack;
        logic [15:0] rdata;
        logic        endf;
        logic        errf;
    } vout_t;

    typedef struct {
        vin_t  i;
        vout_t o;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dma_dev_if dev ();
    dma_mem_if mem ();

    dma_controller #(.ACK_TIMEOUT(16'd8), .PRIORITY(1'b1)) dut (
        .clk  (clk),
        .reset(reset),
        .dev  (dev),
        .mem  (mem)
    );

    function automatic vin_t vi(input logic rqst, input logic rd, input logic [15:0] addr,
                                input logic [15:0] num, input logic ack, input logic [15:0] wdata,
                                input logic ready, input logic resp, input logic [15:0] dout);
        vin_t v;
        v.rqst = rqst; v.rd = rd; v.addr = addr; v.num = num; v.ack = ack;
        v.wdata = wdata; v.ready = ready; v.resp = resp; v.dout = dout;
        return v;
    endfunction

    function automatic vout_t vo(input logic en, input logic [1:0] we, input logic [14:0] maddr,
                                 input logic [15:0] din, input logic dack, input logic [15:0] rdata,
                                 input logic endf, input logic errf);
        vout_t v;
        v.en = en; v.we = we; v.maddr = maddr; v.din = din; v.dack = dack;
        v.rdata = rdata; v.endf = endf; v.errf = errf;
        return v;
    endfunction

    task automatic add(input vin_t a, input vout_t b);
        vec_t v;
        v.i = a;
        v.o = b;
        vecs.push_back(v);
    endtask

    task automatic drive(input vin_t v);
        dev.dev_rqst       = v.rqst;
        dev.dev_rd_wr      = v.rd;
        dev.dev_start_addr = v.addr;
        dev.dev_num_words  = v.num;
        dev.dev_ack        = v.ack;
        dev.dev_wdata      = v.wdata;
        mem.dma_ready      = v.ready;
        mem.dma_resp       = v.resp;
        mem.dma_dout       = v.dout;
    endtask

    function automatic vout_t sample();
        return vo(mem.dma_en, mem.dma_we, mem.dma_addr, mem.dma_din,
                  dev.dev_dma_ack, dev.dev_rdata, dev.dev_end_flag, dev.dev_error_flag);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          ncap;
        int          nend;
        int          nack;
        logic [14:0] caps[2];

        // Write block: 0x0200, 3 words
        add(vi(1,0,16'h0200,3,1,16'h00A1,1,0,0), vo(0,2'b00,15'h000,16'h0000,0,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A1,1,0,0), vo(1,2'b11,15'h100,16'h00A1,0,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A1,1,0,0), vo(0,2'b00,15'h100,16'h00A1,1,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A2,1,0,0), vo(0,2'b00,15'h100,16'h00A1,0,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A2,1,0,0), vo(1,2'b11,15'h101,16'h00A2,0,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A2,1,0,0), vo(0,2'b00,15'h101,16'h00A2,1,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A3,1,0,0), vo(0,2'b00,15'h101,16'h00A2,0,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A3,1,0,0), vo(1,2'b11,15'h102,16'h00A3,0,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A3,1,0,0), vo(0,2'b00,15'h102,16'h00A3,1,16'h0000,0,0));
        add(vi(1,0,16'h0200,3,1,16'h00A3,1,0,0), vo(0,2'b00,15'h102,16'h00A3,0,16'h0000,1,0));
        add(vi(1,0,16'h0200,3,1,16'h00A3,1,0,0), vo(0,2'b00,15'h102,16'h00A3,0,16'h0000,0,0));
        add(vi(0,0,16'h0200,3,1,16'h00A3,1,0,0), vo(0,2'b00,15'h102,16'h00A3,0,16'h0000,0,0));
        // Read block: 0x0300, 2 words; data arrives the cycle after dma_ready
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(0,2'b00,15'h102,16'h00A3,0,16'h0000,0,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(1,2'b00,15'h180,16'h0000,0,16'h0000,0,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(0,2'b00,15'h180,16'h0000,0,16'h0000,0,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h1234), vo(0,2'b00,15'h180,16'h0000,1,16'h1234,0,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(0,2'b00,15'h180,16'h0000,0,16'h1234,0,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(1,2'b00,15'h181,16'h0000,0,16'h1234,0,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(0,2'b00,15'h181,16'h0000,0,16'h1234,0,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h5678), vo(0,2'b00,15'h181,16'h0000,1,16'h5678,0,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,1,0));
        add(vi(1,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,0,0));
        add(vi(0,1,16'h0300,2,1,16'h0000,1,0,16'h0000), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,0,0));
        // Zero words, request held through DRAIN
        add(vi(1,0,16'h0700,0,1,16'h0BAD,1,0,0), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,1,0));
        add(vi(1,0,16'h0700,0,1,16'h0BAD,1,0,0), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,0,0));
        add(vi(1,0,16'h0700,0,1,16'h0BAD,1,0,0), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,0,0));
        add(vi(1,0,16'h0700,0,1,16'h0BAD,1,0,0), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,0,0));
        add(vi(0,0,16'h0700,0,1,16'h0BAD,1,0,0), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,0,0));
        // Memory error on word 2 of 4
        add(vi(1,0,16'h0400,4,1,16'h0011,1,0,0), vo(0,2'b00,15'h181,16'h0000,0,16'h5678,0,0));
        add(vi(1,0,16'h0400,4,1,16'h0011,1,0,0), vo(1,2'b11,15'h200,16'h0011,0,16'h5678,0,0));
        add(vi(1,0,16'h0400,4,1,16'h0011,1,0,0), vo(0,2'b00,15'h200,16'h0011,1,16'h5678,0,0));
        add(vi(1,0,16'h0400,4,1,16'h0022,1,0,0), vo(0,2'b00,15'h200,16'h0011,0,16'h5678,0,0));
        add(vi(1,0,16'h0400,4,1,16'h0022,1,0,0), vo(1,2'b11,15'h201,16'h0022,0,16'h5678,0,0));
        add(vi(1,0,16'h0400,4,1,16'h0022,1,1,0), vo(0,2'b00,15'h201,16'h0022,0,16'h5678,0,1));
        add(vi(1,0,16'h0400,4,1,16'h0033,1,0,0), vo(0,2'b00,15'h201,16'h0022,0,16'h5678,0,0));
        add(vi(1,0,16'h0400,4,1,16'h0033,1,0,0), vo(0,2'b00,15'h201,16'h0022,0,16'h5678,0,0));
        add(vi(0,0,16'h0400,4,1,16'h0033,1,0,0), vo(0,2'b00,15'h201,16'h0022,0,16'h5678,0,0));
        // Abort in WAIT_DEV, then a one-word write proves the FSM is back in IDLE
        add(vi(1,0,16'h0500,5,0,16'h0044,1,0,0), vo(0,2'b00,15'h201,16'h0022,0,16'h5678,0,0));
        add(vi(1,0,16'h0500,5,0,16'h0044,1,0,0), vo(0,2'b00,15'h201,16'h0022,0,16'h5678,0,0));
        add(vi(0,0,16'h0500,5,0,16'h0044,1,0,0), vo(0,2'b00,15'h201,16'h0022,0,16'h5678,0,0));
        add(vi(1,0,16'h0010,1,1,16'h0055,1,0,0), vo(0,2'b00,15'h201,16'h0022,0,16'h5678,0,0));
        add(vi(1,0,16'h0010,1,1,16'h0055,1,0,0), vo(1,2'b11,15'h008,16'h0055,0,16'h5678,0,0));
        add(vi(1,0,16'h0010,1,1,16'h0055,1,0,0), vo(0,2'b00,15'h008,16'h0055,1,16'h5678,0,0));
        add(vi(1,0,16'h0010,1,1,16'h0055,1,0,0), vo(0,2'b00,15'h008,16'h0055,0,16'h5678,1,0));
        add(vi(0,0,16'h0010,1,1,16'h0055,1,0,0), vo(0,2'b00,15'h008,16'h0055,0,16'h5678,0,0));
        add(vi(0,0,16'h0010,1,1,16'h0055,1,0,0), vo(0,2'b00,15'h008,16'h0055,0,16'h5678,0,0));

        reset = 1'b1;
        drive(vi(0,0,0,0,0,0,0,0,0));
        #12;
        check("reset_state", 64'(sample()), 64'(vo(0,2'b00,0,0,0,0,0,0)));
        check("priority", 64'(mem.dma_priority), 64'(1'b1));
        @(negedge clk);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].i);
            tick();
            check($sformatf("vec%0d", i), 64'(sample()), 64'(vecs[i].o));
        end

        // Timeout: dev_ack held low, error exactly 8 cycles after entering WAIT_DEV
        drive(vi(1,0,16'h0600,3,0,0,1,0,0));
        tick();
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("tmo_err_c%0d", k), 64'(dev.dev_error_flag), 64'(k == 8));
        end
        dev.dev_rqst = 1'b0;
        tick();
        tick();

        // Address wrap: byte 0xFFFE, 2 words, handshakes tied high
        drive(vi(1,0,16'hFFFE,2,1,16'h00EE,1,0,0));
        ncap = 0;
        nend = 0;
        caps[0] = '1;
        caps[1] = '1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (mem.dma_en) begin
                if (ncap < 2) caps[ncap] = mem.dma_addr;
                ncap++;
            end
            if (dev.dev_end_flag) nend++;
        end
        check("wrap_accesses", 64'(ncap), 64'd2);
        check("wrap_addr0", 64'(caps[0]), 64'h7FFF);
        check("wrap_addr1", 64'(caps[1]), 64'h0000);
        check("wrap_end", 64'(nend), 64'd1);
        dev.dev_rqst = 1'b0;
        tick();
        tick();

        // Reset while stalled in MEM_REQ, then a fresh one-word transfer
        drive(vi(1,0,16'h0020,2,1,16'h0077,0,0,0));
        tick();
        tick();
        check("rst_pre_en", 64'({mem.dma_en, mem.dma_addr}), 64'({1'b1, 15'h010}));
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", 64'(sample()), 64'(vo(0,2'b00,0,0,0,0,0,0)));
        dev.dev_rqst = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        drive(vi(1,0,16'h0030,1,1,16'h0099,1,0,0));
        ncap = 0;
        nend = 0;
        nack = 0;
        caps[0] = '1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (mem.dma_en) begin
                if (ncap < 1) caps[0] = mem.dma_addr;
                ncap++;
            end
            if (dev.dev_dma_ack) nack++;
            if (dev.dev_end_flag) nend++;
        end
        check("post_rst_addr", 64'(caps[0]), 64'h0018);
        check("post_rst_accesses", 64'(ncap), 64'd1);
        check("post_rst_ack", 64'(nack), 64'd1);
        check("post_rst_end", 64'(nend), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_controller.md
# dma_controller

Responder end of the peripheral DMA protocol. Accepts a block-transfer request from a DMA-capable peripheral (start address, word count, direction) and performs the word accesses on the CPU's memory DMA master port, one word per device handshake. Returns read data, a per-word acknowledge, an end-of-block flag and an error flag to the peripheral. Sits between the peripheral bus devices and the memory backbone DMA port.

## Interface
Parameters:
- ACK_TIMEOUT, 16'd1024: cycles allowed in WAIT_DEV for `dev_ack` before the transfer errors out; 0 disables the timeout.
- PRIORITY, 1'b0: constant value driven on `dma_priority`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- dev_rqst  in  1  transfer request; level, held high by the device for the whole block.
- dev_rd_wr  in  1  direction: 1 = memory→device (read), 0 = device→memory (write).
- dev_start_addr  in  16  byte start address; bit 0 ignored.
- dev_num_words  in  16  number of words in the block.
- dev_ack  in  1  device ready for the next word.
- dev_wdata  in  16  write data from the device.
- dev_rdata  out  16  read data to the device.
- dev_dma_ack  out  1  one-cycle per-word acknowledge.
- dev_end_flag  out  1  one-cycle pulse when the block completes.
- dev_error_flag  out  1  one-cycle pulse on a memory error or a `dev_ack` timeout.
- dma_addr  out  15  memory word address (byte address [15:1]).
- dma_din  out  16  memory write data.
- dma_en  out  1  memory access request.
- dma_we  out  2  byte write enables; 2'b11 for writes, 2'b00 for reads.
- dma_priority  out  1  equals PRIORITY.
- dma_dout  in  16  memory read data; valid the cycle after `dma_ready`.
- dma_ready  in  1  access accepted.
- dma_resp  in  1  error response, qualified by `dma_ready`.

## Operation
- **IDLE**
  - On `dev_rqst`=1, latch `dev_start_addr[15:1]`, `dev_num_words` and `dev_rd_wr`.
  - If the word count is 0, go to END. Otherwise go to WAIT_DEV.
- **WAIT_DEV**
  - If `dev_rqst`=0, go to IDLE (silent abort: no end or error flag).
  - If `dev_ack`=1, go to MEM_REQ.
  - A timeout counter counts cycles spent here. When it reaches ACK_TIMEOUT, go to ERROR. The counter clears on every entry to WAIT_DEV.
- **MEM_REQ**
  - `dma_en`=1, `dma_addr` = current word address, `dma_we` set by direction, `dma_din` = `dev_wdata`. All are held stable until `dma_ready`.
  - On `dma_ready`:
    - `dma_resp`=1 → ERROR.
    - Otherwise, read → RD_CAP; write → ACK.
  - `dev_rqst` falling here does not cancel the access. The abort takes effect in the next WAIT_DEV.
- **RD_CAP**: `dev_rdata` ← `dma_dout`; go to ACK.
- **ACK**
  - `dev_dma_ack`=1 for one cycle. `dev_rdata` is stable this cycle.
  - Word address increments by 1 (mod 2^15, so byte 0xFFFE wraps to 0x0000 with no error).
  - Remaining count decrements by 1. If it reaches 0 → END, else → WAIT_DEV.
- **END**: `dev_end_flag`=1 for one cycle; go to DRAIN.
- **ERROR**: `dev_error_flag`=1 for one cycle; go to DRAIN.
- **DRAIN**: wait for `dev_rqst`=0, then go to IDLE. A held-high request never restarts a block.
- Simultaneous `dev_ack`=0 and `dev_rqst`=0 in WAIT_DEV → IDLE.
- Count 0xFFFF is legal: a full 65535-word transfer.

## Timing
- Reset values: `dma_en`=0, `dma_we`=0, `dma_addr`=0, `dma_din`=0, `dev_rdata`=0, `dev_dma_ack`=0, `dev_end_flag`=0, `dev_error_flag`=0, FSM in IDLE, counters 0. `dma_priority`=PRIORITY always.
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronous). No flag pulses on exit.
- All device-side and memory-side outputs are registered.
- Best-case per-word cost with `dev_ack` and `dma_ready` tied high:
  - write: 3 cycles (WAIT_DEV, MEM_REQ, ACK);
  - read: 4 cycles (adds RD_CAP).
- Request-to-first-access latency: 2 cycles (IDLE→WAIT_DEV→MEM_REQ).
- `dev_end_flag` asserts in the cycle after the last `dev_dma_ack`.

## Structure
- Package `dma_pkg`:
  - FSM state enum (IDLE, WAIT_DEV, MEM_REQ, RD_CAP, ACK, END, ERROR, DRAIN);
  - direction constants DIR_WRITE=0, DIR_READ=1;
  - default ACK_TIMEOUT.
- Sub-module `dma_xfer_counter`: 15-bit word-address register with increment, 16-bit remaining-count register with decrement, and a zero flag. Both registers load from the latch signals in IDLE.
- Top level: FSM, timeout counter, and output registers.

## Test plan
- **Write block**: addr 0x0200, 3 words, `dev_wdata` 0xA1/0xA2/0xA3, `dev_ack`=1, `dma_ready`=1 → memory words 0x0100..0x0102 written with `dma_we`=11; three `dev_dma_ack` pulses 3 cycles apart; one `dev_end_flag`.
- **Read block**: addr 0x0300, 2 words, memory holds 0x1234/0x5678 → `dev_rdata` equals each value during its `dev_dma_ack`; 4 cycles per word; `dev_end_flag` pulses.
- **Zero words / DRAIN**: count 0 → `dev_end_flag` 1 cycle after request, no `dma_en`. With `dev_rqst` held high afterwards, no new transfer starts.
- **Memory error**: `dma_resp`=1 on word 2 of 4 → one `dev_error_flag` pulse, no second `dev_dma_ack`, no `dev_end_flag`.
- **Timeout and wrap**: ACK_TIMEOUT=8 with `dev_ack` held 0 → error pulse 8 cycles after entering WAIT_DEV. Separately, start 0xFFFE, 2 words → `dma_addr` 0x7FFF then 0x0000.
- **Abort and reset**: `dev_rqst` dropped in WAIT_DEV → IDLE with no flags. Reset asserted during MEM_REQ → `dma_en`=0 immediately; a fresh request afterwards completes normally.
